fetch_unit: RTL and testbench

Program-counter and IF/ID pipeline stage that sits directly upstream of the instruction memory.
- Drives the 8-bit byte address into the memory and captures the returned 32-bit little-endian-assembled instruction.
- Presents the instruction to decode with a valid/ready handshake.
- Handles branch redirects from execute and halts on an all-zero instruction word.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program counter and IF/ID pipeline register feeding decode over a valid/ready handshake.
// Fetch stops on the halt word or on a misaligned redirect. Only reset restarts it.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_insn,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_insn,
  output logic [7:0]  id_pc,
  output logic [6:0]  id_opcode,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  // state | meaning
  // BOOT  | first cycle after reset, PC = RESET_PC, nothing issued
  // RUN   | fetching and issuing one instruction per accepted cycle
  // HALT  | fetch stopped, PC frozen, only reset leaves
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t     state, state_nxt;
  logic [7:0] pc, pc_nxt;
  logic       valid_nxt;
  logic       load_id;
  logic       mis_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = id_valid;
    load_id   = 1'b0;
    mis_set   = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        valid_nxt = 1'b0;
      end
      RUN: begin
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          mis_set   = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = HALT;
        end else if (redirect_valid) begin
          // squash any un-accepted instruction, even during a stall
          pc_nxt    = redirect_target;
          valid_nxt = 1'b0;
        end else if (id_valid && !id_ready) begin
          valid_nxt = 1'b1;
        end else if (imem_insn == HALT_WORD) begin
          valid_nxt = 1'b0;
          state_nxt = HALT;
        end else begin
          load_id   = 1'b1;
          valid_nxt = 1'b1;
          pc_nxt    = pc + 8'd4;
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = HALT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      id_valid     <= 1'b0;
      id_insn      <= 32'h0;
      id_pc        <= 8'h00;
      id_opcode    <= 7'h00;
      misalign_err <= 1'b0;
      fetch_count  <= 16'h0000;
    end else begin
      pc       <= pc_nxt;
      id_valid <= valid_nxt;
      if (mis_set) misalign_err <= 1'b1;
      if (load_id) begin
        id_insn   <= imem_insn;
        id_opcode <= imem_insn[6:0];
        id_pc     <= pc;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      end
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle vectors plus hand-written
// sequences for async reset and PC wrap (second instance with RESET_PC = 0xFC).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_insn;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_target = 8'h00;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_insn;
  logic [7:0]  id_pc;
  logic [6:0]  id_opcode;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic        w_rst_n = 1'b0;
  logic [7:0]  w_addr;
  logic [31:0] w_insn;
  logic        w_valid;
  logic [31:0] w_id_insn;
  logic [7:0]  w_pc;
  logic [6:0]  w_opcode;
  logic        w_halted;
  logic        w_mis;
  logic [15:0] w_count;

  logic [31:0] mem [64];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_insn = mem[imem_addr[7:2]];
  assign w_insn    = mem[w_addr[7:2]];

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_insn(imem_insn),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_insn(id_insn), .id_pc(id_pc),
    .id_opcode(id_opcode), .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(8'hFC)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem_addr(w_addr), .imem_insn(w_insn),
    .redirect_valid(1'b0), .redirect_target(8'h00),
    .id_ready(1'b1), .id_valid(w_valid), .id_insn(w_id_insn), .id_pc(w_pc),
    .id_opcode(w_opcode), .halted(w_halted), .misalign_err(w_mis),
    .fetch_count(w_count)
  );

  typedef struct {
    logic        rv;
    logic [7:0]  rt;
    logic        rdy;
    logic        v;
    logic [7:0]  pc;
    logic [31:0] insn;
    logic [7:0]  addr;
    logic        halt;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 8'h00;
    id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drive inputs, take one rising edge, compare, return at the following falling edge
  task automatic run_vec(input int i);
    logic [6:0] exp_op;
    redirect_valid  = tbl[i].rv;
    redirect_target = tbl[i].rt;
    id_ready        = tbl[i].rdy;
    @(posedge clk);
    #1;
    check($sformatf("v%0d id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].v});
    check($sformatf("v%0d imem_addr", i), {24'b0, imem_addr}, {24'b0, tbl[i].addr});
    check($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, tbl[i].halt});
    check($sformatf("v%0d misalign_err", i), {31'b0, misalign_err}, {31'b0, tbl[i].mis});
    check($sformatf("v%0d fetch_count", i), {16'b0, fetch_count}, {16'b0, tbl[i].cnt});
    if (tbl[i].v) begin
      exp_op = tbl[i].insn[6:0];
      check($sformatf("v%0d id_pc", i), {24'b0, id_pc}, {24'b0, tbl[i].pc});
      check($sformatf("v%0d id_insn", i), id_insn, tbl[i].insn);
      check($sformatf("v%0d id_opcode", i), {25'b0, id_opcode}, {25'b0, exp_op});
    end
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //             rv    rt     rdy   v     pc     insn           addr   halt  mis   cnt
    // straight line ending on the halt word at 0x08
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,         8'h00, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'h00500093, 8'h04, 1'b0, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 32'h00A00113, 8'h08, 1'b0, 1'b0, 16'd2};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,         8'h08, 1'b1, 1'b0, 16'd2};
    tbl[4]  = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 32'h0,         8'h08, 1'b1, 1'b0, 16'd2};
    // BOOT ignores redirect, stall, redirect under stall, misaligned redirect
    tbl[5]  = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 32'h0,         8'h00, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'h00500093, 8'h04, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 32'h00A00113, 8'h08, 1'b0, 1'b0, 16'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 32'h00A00113, 8'h08, 1'b0, 1'b0, 16'd2};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 32'h00A00113, 8'h08, 1'b0, 1'b0, 16'd2};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 32'h00A00113, 8'h08, 1'b0, 1'b0, 16'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 32'h00F00193, 8'h0C, 1'b0, 1'b0, 16'd3};
    tbl[12] = '{1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 32'h0,         8'h40, 1'b0, 1'b0, 16'd3};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 32'h00100213, 8'h44, 1'b0, 1'b0, 16'd4};
    tbl[14] = '{1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 32'h0,         8'h44, 1'b1, 1'b1, 16'd4};
    tbl[15] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 32'h0,         8'h44, 1'b1, 1'b1, 16'd4};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,         8'h44, 1'b1, 1'b1, 16'd4};

    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[0]  = 32'h00500093;
    mem[1]  = 32'h00A00113;
    mem[2]  = 32'h00000000;
    mem[63] = 32'h00300313;

    #12;
    check("reset id_valid", {31'b0, id_valid}, 32'd0);
    check("reset imem_addr", {24'b0, imem_addr}, 32'h00);
    check("reset id_insn", id_insn, 32'h0);
    check("reset id_pc", {24'b0, id_pc}, 32'h0);
    check("reset halted", {31'b0, halted}, 32'd0);
    check("reset fetch_count", {16'b0, fetch_count}, 32'd0);

    do_reset();
    for (int i = 0; i <= 4; i++) run_vec(i);

    mem[2]  = 32'h00F00193;
    mem[3]  = 32'h00000000;
    mem[4]  = 32'h00700393;
    mem[16] = 32'h00100213;
    mem[17] = 32'h00200293;
    do_reset();
    for (int i = 5; i <= 16; i++) run_vec(i);

    rst_n = 1'b0;
    #1;
    check("rst clears misalign_err", {31'b0, misalign_err}, 32'd0);
    check("rst clears halted", {31'b0, halted}, 32'd0);

    // async reset mid-cycle while an instruction is live
    do_reset();
    id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("async pre id_valid", {31'b0, id_valid}, 32'd1);
    check("async pre imem_addr", {24'b0, imem_addr}, 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("async id_valid", {31'b0, id_valid}, 32'd0);
    check("async imem_addr", {24'b0, imem_addr}, 32'h00);
    check("async fetch_count", {16'b0, fetch_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async boot id_valid", {31'b0, id_valid}, 32'd0);
    check("async boot imem_addr", {24'b0, imem_addr}, 32'h00);
    @(posedge clk);
    #1;
    check("async first id_valid", {31'b0, id_valid}, 32'd1);
    check("async first id_pc", {24'b0, id_pc}, 32'h00);

    // PC wrap from 0xFC to 0x00
    @(negedge clk);
    w_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("wrap boot addr", {24'b0, w_addr}, 32'hFC);
    check("wrap boot valid", {31'b0, w_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("wrap issue valid", {31'b0, w_valid}, 32'd1);
    check("wrap issue pc", {24'b0, w_pc}, 32'hFC);
    check("wrap issue insn", w_id_insn, 32'h00300313);
    check("wrap addr", {24'b0, w_addr}, 32'h00);
    @(posedge clk);
    #1;
    check("wrap next pc", {24'b0, w_pc}, 32'h00);
    check("wrap next addr", {24'b0, w_addr}, 32'h04);
    check("wrap next count", {16'b0, w_count}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
